// File: rtl/circular_pointer_fifo_param.sv
// ---------------------------------------------------------------------------
// circular_pointer_fifo_param
//
// Parametrised show-ahead FIFO built on explicit-wrap circular pointers, so
// any DEPTH >= 2 works, including non-power-of-two depths. It reports
// occupancy, almost-full and almost-empty levels, and rejected requests.
// It runs in a single clock domain between a producer and a consumer.
//
// Parameters
//   WIDTH      data word width
//   DEPTH      number of entries (>= 2)
//   AF_THRESH  almost_full  when count >= AF_THRESH (1..DEPTH)
//   AE_THRESH  almost_empty when count <= AE_THRESH (0..DEPTH-1)
//
// Ports
//   clk           clock, rising edge
//   rst           synchronous active-high reset
//   push          write request; data_in is written when the push is accepted
//   pop           read request
//   data_in       write data
//   data_out      head word, show-ahead; valid while empty = 0
//   full, empty   count == DEPTH / count == 0
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         current occupancy
//   overflow      a push was rejected
//   underflow     a pop was rejected
//
// Build option
//   CPF_ERR_STICKY_EN  If defined, overflow and underflow are sticky until
//                      rst. Otherwise each one is a one-cycle registered
//                      pulse per rejected request.
// ---------------------------------------------------------------------------
module circular_pointer_fifo_param #(
   parameter int WIDTH     = 8,
   parameter int DEPTH     = 8,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       push,
   input  logic                       pop,
   input  logic [WIDTH-1:0]           data_in,
   output logic [WIDTH-1:0]           data_out,
   output logic                       full,
   output logic                       empty,
   output logic                       almost_full,
   output logic                       almost_empty,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       overflow,
   output logic                       underflow
);

   localparam int PW = (DEPTH > 2) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);
   localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
   localparam logic [CW-1:0] AF_LVL   = CW'(AF_THRESH);
   localparam logic [CW-1:0] AE_LVL   = CW'(AE_THRESH);

   logic [WIDTH-1:0] entries [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW-1:0]    wr_ptr_nxt;
   logic [PW-1:0]    rd_ptr_nxt;
   logic             push_ok;
   logic             pop_ok;
   logic             ovf_evt;
   logic             udf_evt;

   // A full FIFO takes a push only when a pop frees a slot in the same cycle.
   assign pop_ok  = pop & (count != '0);
   assign push_ok = push & ((count != CNT_FULL) | pop_ok);
   assign ovf_evt = push & ~push_ok;
   assign udf_evt = pop & ~pop_ok;

   // Wrap explicitly at DEPTH-1 instead of at 2^PW.
   assign wr_ptr_nxt = (wr_ptr == PTR_LAST) ? '0 : wr_ptr + PW'(1);
   assign rd_ptr_nxt = (rd_ptr == PTR_LAST) ? '0 : rd_ptr + PW'(1);

   // Storage is not reset, so it stays out of the reset block.
   always_ff @(posedge clk) begin
      if (push_ok && !rst) begin
         entries[wr_ptr] <= data_in;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr_nxt;
         end
         if (pop_ok) begin
            rd_ptr <= rd_ptr_nxt;
         end
         case ({push_ok, pop_ok})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
`ifdef CPF_ERR_STICKY_EN
         overflow  <= overflow  | ovf_evt;
         underflow <= underflow | udf_evt;
`else
         overflow  <= ovf_evt;
         underflow <= udf_evt;
`endif
      end
   end

   // The head is read from the registered pointer, and the flags are decoded
   // from the registered count. No output depends on push or pop.
   assign data_out     = entries[rd_ptr];
   assign full         = (count == CNT_FULL);
   assign empty        = (count == '0);
   assign almost_full  = (count >= AF_LVL);
   assign almost_empty = (count <= AE_LVL);

endmodule

// File: tb/tb_circular_pointer_fifo_param.sv
module tb_circular_pointer_fifo_param;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // DUT a: DEPTH=5, default thresholds (AF=4, AE=1)
   logic       a_push, a_pop;
   logic [7:0] a_din, a_dout;
   logic       a_full, a_empty, a_af, a_ae, a_ov, a_un;
   logic [2:0] a_cnt;

   // DUT b: DEPTH=8, AF=6, AE=2
   logic       b_push, b_pop;
   logic [7:0] b_din, b_dout;
   logic       b_full, b_empty, b_af, b_ae, b_ov, b_un;
   logic [3:0] b_cnt;

   circular_pointer_fifo_param #(.WIDTH(8), .DEPTH(5)) u_a (
      .clk(clk), .rst(rst), .push(a_push), .pop(a_pop), .data_in(a_din),
      .data_out(a_dout), .full(a_full), .empty(a_empty),
      .almost_full(a_af), .almost_empty(a_ae), .count(a_cnt),
      .overflow(a_ov), .underflow(a_un));

   circular_pointer_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) u_b (
      .clk(clk), .rst(rst), .push(b_push), .pop(b_pop), .data_in(b_din),
      .data_out(b_dout), .full(b_full), .empty(b_empty),
      .almost_full(b_af), .almost_empty(b_ae), .count(b_cnt),
      .overflow(b_ov), .underflow(b_un));

   int total = 0;
   int bad   = 0;

   // Reference model: a queue of stored words plus the expected error flags.
   logic [7:0] qa[$];
   logic [7:0] qb[$];
   logic       ea_ov = 1'b0, ea_un = 1'b0, eb_ov = 1'b0, eb_un = 1'b0;
   logic [7:0] last_pop_b;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic upd(input int depth, input logic p, input logic o, input logic [7:0] d,
                      inout logic [7:0] q[$], inout logic ov, inout logic un,
                      output logic [7:0] popped);
      bit pok, wok;
      pok = o && (q.size() > 0);
      wok = p && ((q.size() < depth) || pok);
      popped = 8'h00;
      if (pok) popped = q.pop_front();
      if (wok) q.push_back(d);
`ifdef CPF_ERR_STICKY_EN
      ov = ov | (p & !wok);
      un = un | (o & !pok);
`else
      ov = p & !wok;
      un = o & !pok;
`endif
   endtask

   task automatic chk_dut(input string n, input int depth, input int af, input int ae,
                          input logic [7:0] q[$], input logic ov, input logic un,
                          input int cnt, input logic f, input logic e, input logic afo,
                          input logic aeo, input logic ovo, input logic uno,
                          input logic [7:0] dout);
      int s;
      s = q.size();
      chk({n, ".count"}, cnt, s);
      chk({n, ".full"}, f, (s == depth));
      chk({n, ".empty"}, e, (s == 0));
      chk({n, ".almost_full"}, afo, (s >= af));
      chk({n, ".almost_empty"}, aeo, (s <= ae));
      chk({n, ".overflow"}, ovo, ov);
      chk({n, ".underflow"}, uno, un);
      if (s > 0) chk({n, ".data_out"}, dout, q[0]);
   endtask

   task automatic check_all();
      chk_dut("a", 5, 4, 1, qa, ea_ov, ea_un, int'(a_cnt), a_full, a_empty,
              a_af, a_ae, a_ov, a_un, a_dout);
      chk_dut("b", 8, 6, 2, qb, eb_ov, eb_un, int'(b_cnt), b_full, b_empty,
              b_af, b_ae, b_ov, b_un, b_dout);
   endtask

   // One clock: drive both DUTs, step the model, check after the edge.
   task automatic cyc(input logic ap, input logic ao, input logic [7:0] ad,
                      input logic bp, input logic bo, input logic [7:0] bd);
      logic [7:0] dummy;
      a_push = ap; a_pop = ao; a_din = ad;
      b_push = bp; b_pop = bo; b_din = bd;
      @(posedge clk);
      #1;
      upd(5, ap, ao, ad, qa, ea_ov, ea_un, dummy);
      upd(8, bp, bo, bd, qb, eb_ov, eb_un, last_pop_b);
      check_all();
   endtask

   task automatic ca(input logic p, input logic o, input logic [7:0] d);
      cyc(p, o, d, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic cb(input logic p, input logic o, input logic [7:0] d);
      cyc(1'b0, 1'b0, 8'h00, p, o, d);
   endtask

   task automatic do_reset(input logic p);
      rst = 1'b1;
      a_push = p; a_pop = 1'b0; a_din = 8'h5A;
      b_push = p; b_pop = 1'b0; b_din = 8'hA5;
      @(posedge clk);
      #1;
      rst = 1'b0;
      qa.delete(); qb.delete();
      ea_ov = 1'b0; ea_un = 1'b0; eb_ov = 1'b0; eb_un = 1'b0;
      check_all();
   endtask

   initial begin
      rst = 1'b0;
      a_push = 0; a_pop = 0; a_din = 0;
      b_push = 0; b_pop = 0; b_din = 0;
      @(posedge clk);
      #1;
      do_reset(1'b0);

      // Depth-5 fill and drain in order.
      for (int i = 0; i < 5; i++) ca(1'b1, 1'b0, 8'h11 + 8'(i));
      chk("a.full_after_fill", a_full, 1'b1);
      for (int i = 0; i < 5; i++) begin
         chk("a.head_order", a_dout, 8'h11 + 8'(i));
         ca(1'b0, 1'b1, 8'h00);
      end
      chk("a.empty_after_drain", a_empty, 1'b1);

      // Alternating push and pop, so the pointers wrap 4->0 more than once.
      for (int i = 0; i < 12; i++) begin
         ca(1'b1, 1'b0, 8'h40 + 8'(i));
         chk("a.alt_head", a_dout, 8'h40 + 8'(i));
         ca(1'b0, 1'b1, 8'h00);
      end

      // Depth-8 tests: overflow, then push and pop together while full.
      for (int i = 0; i < 8; i++) cb(1'b1, 1'b0, 8'(i + 1));
      cb(1'b1, 1'b0, 8'hAA);
      chk("b.ovf_count", b_cnt, 4'd8);
      cb(1'b1, 1'b1, 8'hBB);
      chk("b.head_advanced", b_dout, 8'h02);
      for (int i = 0; i < 8; i++) cb(1'b0, 1'b1, 8'h00);
      chk("b.last_popped", last_pop_b, 8'hBB);

      // Empty FIFO: underflow, then push and pop together.
      cb(1'b0, 1'b1, 8'h00);
      cb(1'b1, 1'b1, 8'h3C);
      chk("b.pp_empty_dout", b_dout, 8'h3C);
      chk("b.pp_empty_cnt", b_cnt, 4'd1);
      cb(1'b0, 1'b1, 8'h00);

      // Threshold walk 0..8; the model checks the flags at each level.
      for (int i = 0; i < 8; i++) cb(1'b1, 1'b0, 8'($urandom));
      for (int i = 0; i < 8; i++) cb(1'b0, 1'b1, 8'h00);

      // Reset mid-operation with push held, then error-flag persistence.
      for (int i = 0; i < 4; i++) ca(1'b1, 1'b0, 8'($urandom));
      do_reset(1'b1);
      chk("a.rst_empty", a_empty, 1'b1);
      for (int i = 0; i < 5; i++) ca(1'b1, 1'b0, 8'($urandom));
      ca(1'b1, 1'b0, 8'hEE);
      chk("a.ovf_set", a_ov, 1'b1);
      for (int i = 0; i < 3; i++) ca(1'b0, 1'b0, 8'h00);
      do_reset(1'b0);

      // Random traffic on both DUTs.
      for (int i = 0; i < 400; i++) begin
         cyc(1'($urandom), 1'($urandom), 8'($urandom),
             1'($urandom), 1'($urandom), 8'($urandom));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
